// File: rtl/sreg_rr_arbiter.sv
// Round-robin arbiter owning a shared preset state register (LOAD/SET/CLR/HOLD per transaction).
// Optional SREG_ARB_LOCK_EN adds a per-requester lock input that lets a winner keep priority.
module sreg_rr_arbiter #(
    parameter int unsigned            NREQ    = 4,
    parameter int unsigned            WIDTH   = 4,
    parameter logic [WIDTH-1:0]       RST_VAL = 4'b1101,
    parameter logic [WIDTH-1:0]       SET_VAL = 4'b0110
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NREQ-1:0]           req,
    input  logic [2*NREQ-1:0]         op,
    input  logic [WIDTH*NREQ-1:0]     wdata,
`ifdef SREG_ARB_LOCK_EN
    input  logic [NREQ-1:0]           lock,
`endif
    output logic [NREQ-1:0]           gnt,
    output logic [NREQ-1:0]           done,
    output logic [$clog2(NREQ)-1:0]   owner,
    output logic                      busy,
    output logic [WIDTH-1:0]          q
);

    localparam int unsigned    OW      = $clog2(NREQ);
    localparam logic [NREQ-1:0] ONE    = NREQ'(1);
    localparam logic [1:0]     OP_LOAD = 2'b00;
    localparam logic [1:0]     OP_SET  = 2'b01;
    localparam logic [1:0]     OP_CLR  = 2'b10;
    localparam logic [1:0]     OP_HOLD = 2'b11;

    typedef enum logic [1:0] {IDLE, GRANT, DONE} state_t;

    state_t             state;
    logic [OW-1:0]      ptr;
    logic [OW-1:0]      win;
    logic [1:0]         lop;
    logic [WIDTH-1:0]   ldata;

    logic               found_c;
    logic [OW-1:0]      widx_c;
    logic [1:0]         wop_c;
    logic [WIDTH-1:0]   wdata_c;

`ifdef SREG_ARB_LOCK_EN
    logic               llock;
    logic               locked;
    logic [OW-1:0]      lidx;
`endif

    // Winner search: a held lock takes precedence, otherwise first request at or after ptr.
    always_comb begin
        found_c = 1'b0;
        widx_c  = ptr;
`ifdef SREG_ARB_LOCK_EN
        if (locked && req[lidx]) begin
            found_c = 1'b1;
            widx_c  = lidx;
        end
`endif
        for (int unsigned i = 0; i < NREQ; i++) begin
            int unsigned k;
            k = int'(ptr) + i;
            if (k >= NREQ) begin
                k = k - NREQ;
            end
            if (!found_c && req[OW'(k)]) begin
                found_c = 1'b1;
                widx_c  = OW'(k);
            end
        end
        // Only the winner's lane is selected, so non-winner X never reaches the latches.
        wop_c   = op[int'(widx_c)*2 +: 2];
        wdata_c = wdata[int'(widx_c)*int'(WIDTH) +: WIDTH];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            gnt   <= '0;
            done  <= '0;
            busy  <= 1'b0;
            owner <= '0;
            ptr   <= '0;
            win   <= '0;
            lop   <= OP_HOLD;
            ldata <= '0;
            q     <= RST_VAL;
`ifdef SREG_ARB_LOCK_EN
            llock  <= 1'b0;
            locked <= 1'b0;
            lidx   <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    gnt  <= '0;
                    done <= '0;
                    busy <= 1'b0;
                    if (found_c) begin
                        state <= GRANT;
                        gnt   <= ONE << widx_c;
                        busy  <= 1'b1;
                        owner <= widx_c;
                        win   <= widx_c;
                        lop   <= wop_c;
                        ldata <= wdata_c;
`ifdef SREG_ARB_LOCK_EN
                        llock <= lock[widx_c];
`endif
                    end
                end
                GRANT: begin
                    state <= DONE;
                    gnt   <= '0;
                    done  <= ONE << win;
                    case (lop)
                        OP_LOAD: q <= ldata;
                        OP_SET:  q <= SET_VAL;
                        OP_CLR:  q <= RST_VAL;
                        default: q <= q;
                    endcase
                end
                DONE: begin
                    state <= IDLE;
                    done  <= '0;
                    busy  <= 1'b0;
`ifdef SREG_ARB_LOCK_EN
                    if (llock) begin
                        locked <= 1'b1;
                        lidx   <= win;
                    end else begin
                        locked <= 1'b0;
                        ptr    <= (win == OW'(NREQ-1)) ? '0 : OW'(win + OW'(1));
                    end
`else
                    ptr <= (win == OW'(NREQ-1)) ? '0 : OW'(win + OW'(1));
`endif
                end
                default: begin
                    state <= IDLE;
                    gnt   <= '0;
                    done  <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
